clk_period_monitor: RTL and testbench

- Downstream checker for the 13-channel derived-clock bus produced by the event scheduler.
- Samples each channel on clk_i and measures the half-period between toggles in unfrozen clk_i cycles.
- Compares each measurement against that channel's expected half-period and raises sticky per-channel errors.
- Reports a global lock once every channel has shown consecutive good half-periods; used by the bench and by bring-up logic to qualify the derived clocks.

---
 rtl/clk_period_monitor.sv | 134 +++++++++++++
 tb/tb_clk_period_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// Derived-clock half-period checker.
// Flags per-channel period errors and reports a global lock.
module clk_period_monitor #(
  parameter int NCLK   = 13,
  parameter int CW     = 5,
  parameter int HP_MAX = 14,
  parameter int LOCK_N = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            freeze,
  input  logic            clr_i,
  input  logic [NCLK-1:0] clk_in,
  output logic [NCLK-1:0] edge_o,
  output logic [NCLK-1:0] err_o,
  output logic            lock_o,
  input  logic [3:0]      sel_i,
  output logic [CW-1:0]   meas_o
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0] RUN_MAX = GW'(LOCK_N);

  logic [NCLK-1:0] prev;
  logic [NCLK-1:0] tog;
  logic [NCLK-1:0] edge_q;
  logic [NCLK-1:0] good_full;
  logic [NCLK-1:0] err_v;
  logic [CW-1:0]   meas_a [NCLK];
  logic            lock_q;

  assign tog = clk_in ^ prev;

  // sample register; clear re-seeds it so no toggle is seen
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev <= '0;
    end else if (clr_i || !freeze) begin
      prev <= clk_in;
    end
  end

  // one-cycle edge pulse per detected toggle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= '0;
    end else if (clr_i || freeze) begin
      edge_q <= '0;
    end else begin
      edge_q <= tog;
    end
  end

  assign edge_o = edge_q & ~{NCLK{freeze}};

  for (genvar k = 0; k < NCLK; k++) begin : g_ch
    localparam logic [CW-1:0] HP = CW'(HP_MAX - k);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] meas;
    logic [GW-1:0] run;
    logic          armed;
    logic          err;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // half-period counter, arming, check and stuck detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt   <= '0;
        meas  <= '0;
        run   <= '0;
        armed <= 1'b0;
        err   <= 1'b0;
      end else if (clr_i) begin
        cnt   <= '0;
        meas  <= '0;
        run   <= '0;
        armed <= 1'b0;
        err   <= 1'b0;
      end else if (!freeze) begin
        if (tog[k]) begin
          cnt  <= CW'(1);
          meas <= cnt;
          if (!armed) begin
            armed <= 1'b1;
          end else if (cnt == HP) begin
            if (run != RUN_MAX) begin
              run <= run + 1'b1;
            end
          end else begin
            err <= 1'b1;
            run <= '0;
          end
        end else begin
          cnt <= cnt_inc;
          if (armed && cnt == CNT_MAX - 1'b1) begin
            err <= 1'b1;
          end
        end
      end
    end

    assign err_v[k]     = err;
    assign meas_a[k]    = meas;
    assign good_full[k] = (run == RUN_MAX);
  end

  assign err_o = err_v;

  // global lock: every channel saturated and no error latched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
    end else if (clr_i) begin
      lock_q <= 1'b0;
    end else if (!freeze) begin
      lock_q <= (&good_full) && !(|err_v);
    end
  end

  assign lock_o = lock_q;

  // readback mux; out-of-range selects read zero
  always_comb begin
    meas_o = '0;
    if (int'(sel_i) < NCLK) begin
      meas_o = meas_a[sel_i];
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor.
// Drives a 13-channel derived clock bus and checks flags.
module tb_clk_period_monitor;
  localparam int N = 13;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          freeze = 1'b0;
  logic          clr_i = 1'b0;
  logic [N-1:0]  clk_in = '0;
  logic [N-1:0]  edge_o;
  logic [N-1:0]  err_o;
  logic          lock_o;
  logic [3:0]    sel_i = '0;
  logic [4:0]    meas_o;

  int            checks = 0;
  int            errors = 0;
  int            tc [N];
  logic [N-1:0]  en = '0;
  bit            sfrz = 1'b0;

  clk_period_monitor dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .freeze (freeze),
    .clr_i  (clr_i),
    .clk_in (clk_in),
    .edge_o (edge_o),
    .err_o  (err_o),
    .lock_o (lock_o),
    .sel_i  (sel_i),
    .meas_o (meas_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one clock; then advance the model scheduler
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (!sfrz) begin
      for (int k = 0; k < N; k++) begin
        if (en[k]) begin
          tc[k]++;
          if (tc[k] == 14 - k) begin
            clk_in[k] = ~clk_in[k];
            tc[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic rd(input logic [3:0] s,
                    input logic [4:0] exp,
                    input string tag);
    sel_i = s;
    #1;
    chk(tag, meas_o, exp);
  endtask

  task automatic start_lock();
    for (int k = 0; k < N; k++) tc[k] = 0;
    clk_in = '1;
    en = '1;
    tick();
    chk("edge_all", edge_o, 13'h1fff);
    chk("err_start", err_o, 0);
    chk("lock_start", lock_o, 0);
    tick();
    chk("edge_none", edge_o, 0);
    tick();
    chk("edge_c12", edge_o, 13'h1000);
    rd(4'd12, 5'd2, "meas12_first");
    tick();
    chk("edge_c11", edge_o, 13'h0800);
    repeat (53) tick();
    chk("lock_pre", lock_o, 0);
    tick();
    chk("lock_up", lock_o, 1);
    chk("err_lock", err_o, 0);
    rd(4'd0, 5'd14, "meas0");
    rd(4'd12, 5'd2, "meas12");
  endtask

  initial begin
    #12;
    chk("rst_edge", edge_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_lock", lock_o, 0);
    chk("rst_meas", meas_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    start_lock();

    // channel 5 runs one cycle short
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tc[5] == 0) break;
    end
    tc[5] = 1;
    repeat (8) tick();
    chk("short_pre", err_o, 0);
    tick();
    chk("short_err", err_o, 13'h0020);
    chk("short_lock_hold", lock_o, 1);
    rd(4'd5, 5'd8, "short_meas");
    tick();
    chk("short_lock_drop", lock_o, 0);
    chk("short_err_hold", err_o, 13'h0020);

    // channel 12 stops toggling
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tc[12] == 0) break;
    end
    en[12] = 1'b0;
    repeat (30) tick();
    chk("stuck_pre", err_o, 13'h0020);
    tick();
    chk("stuck_err", err_o, 13'h1020);
    repeat (10) tick();
    chk("stuck_hold", err_o, 13'h1020);
    rd(4'd12, 5'd2, "stuck_meas");

    // clear and re-acquire
    tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_err", err_o, 0);
    chk("clr_lock", lock_o, 0);
    rd(4'd5, 5'd0, "clr_meas");
    tc[12] = 0;
    en[12] = 1'b1;
    repeat (50) tick();
    chk("relock_early", lock_o, 0);
    for (int i = 0; i < 80; i++) begin
      if (lock_o) break;
      tick();
    end
    chk("relock", lock_o, 1);
    chk("relock_err", err_o, 0);

    // freeze monitor and scheduler together
    freeze = 1'b1;
    sfrz = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("frz_edge", edge_o, 0);
    end
    chk("frz_err", err_o, 0);
    freeze = 1'b0;
    sfrz = 1'b0;
    repeat (60) tick();
    chk("thaw_err", err_o, 0);
    chk("thaw_lock", lock_o, 1);
    rd(4'd0, 5'd14, "thaw_meas0");
    rd(4'd7, 5'd7, "thaw_meas7");
    rd(4'd12, 5'd2, "thaw_meas12");

    // asynchronous reset mid-run
    tick();
    sel_i = 4'd0;
    #3;
    rst_ni = 1'b0;
    clk_in = '0;
    en = '0;
    #1;
    chk("arst_edge", edge_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_lock", lock_o, 0);
    chk("arst_meas", meas_o, 0);
    repeat (3) @(posedge clk_i);
    #4;
    rst_ni = 1'b1;
    tick();
    tick();
    start_lock();
    rd(4'd14, 5'd0, "sel14");
    rd(4'd13, 5'd0, "sel13");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
